// File: rtl/sprite_mem_loader_if.sv
// Bus between a pixel source (host/UART front end) and sprite_mem_loader.
// Carries the command, the pixel stream, the sprite RAM write port and status.
interface sprite_mem_loader_if #(
    parameter int NUM_SPRITES = 2
);
    logic                   start;
    logic [5:0]             select;
    logic                   pix_valid;
    logic [1:0]             pix_data;
    logic                   pix_ready;
    logic [NUM_SPRITES-1:0] ram_wen;
    logic [7:0]             ram_address;
    logic [1:0]             ram_data;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [9:0]             checksum;

    // Pixel source side
    modport master (
        output start, select, pix_valid, pix_data,
        input  pix_ready, ram_wen, ram_address, ram_data, busy, done, err, checksum
    );

    // Loader side
    modport slave (
        input  start, select, pix_valid, pix_data,
        output pix_ready, ram_wen, ram_address, ram_data, busy, done, err, checksum
    );
endinterface

// File: rtl/sprite_mem_loader.sv
// sprite_mem_loader: streams 256 2-bit pixels into one 16x16 sprite pattern RAM.
// Address order is {x, y} with y as the fast index (0x00, 0x01 ... 0xFF).
// All outputs are registered; a write appears one cycle after the pixel is accepted.
// Optional feature macro: SPRITE_LOADER_CHECKSUM_EN (running pixel sum reported on done).
module sprite_mem_loader #(
    parameter int NUM_SPRITES = 2
) (
    input  logic                clock,
    input  logic                reset,
    sprite_mem_loader_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [5:0]             sel_q, sel_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [7:0]             addr_q, addr_d;
    logic [1:0]             data_q, data_d;
    logic [NUM_SPRITES-1:0] wen_q, wen_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic accept;
    logic sel_legal;
    logic last_pix;

    // pix_ready is simply the LOAD state, so acceptance needs only pix_valid
    assign accept    = (state_q == LOAD) && bus.pix_valid;
    assign sel_legal = ({26'd0, bus.select} < NUM_SPRITES);
    assign last_pix  = (cnt_q == 8'hFF);

    // One-hot write enable: only RAMs that exist get a bit, so illegal targets cannot be written
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_wen
        assign wen_d[gi] = accept && (sel_q == 6'(gi));
    end

    // Next-state and next-output logic for the command/stream FSM
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (sel_legal) begin
                        sel_d   = bus.select;
                        cnt_d   = 8'h00;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                // start is deliberately ignored here: a load always runs to completion
                if (accept) begin
                    addr_d = cnt_q;
                    data_d = bus.pix_data;
                    cnt_d  = cnt_q + 8'd1;
                    if (last_pix) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wen_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [9:0] sum_q, sum_d;
    logic [9:0] chk_q, chk_d;

    // Running sum of accepted pixels; published to checksum together with done
    always_comb begin
        sum_d = sum_q;
        chk_d = chk_q;
        if (state_q == IDLE && bus.start && sel_legal) begin
            sum_d = 10'd0;
        end else if (accept) begin
            sum_d = sum_q + 10'(bus.pix_data);
            if (last_pix) begin
                chk_d = sum_q + 10'(bus.pix_data);
            end
        end
    end

    // Sum and published checksum registers
    always_ff @(posedge clock) begin
        if (reset) begin
            sum_q <= '0;
            chk_q <= '0;
        end else begin
            sum_q <= sum_d;
            chk_q <= chk_d;
        end
    end

    assign bus.checksum = chk_q;
`else
    assign bus.checksum = 10'd0;
`endif

    assign bus.pix_ready   = (state_q == LOAD);
    assign bus.busy        = (state_q == LOAD);
    assign bus.ram_wen     = wen_q;
    assign bus.ram_address = addr_q;
    assign bus.ram_data    = data_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: doc/sprite_mem_loader.md
# sprite_mem_loader

Write-side companion of the static sprite memory. It receives a start command with a sprite number, then a stream of 2-bit pixels over a valid/ready handshake. Each pixel is written into that sprite's 16x16 pattern RAM at the address the sprite reader uses, so sprites can be (re)loaded at run time from a host or UART front end. It drives the RAM write ports (`wen`, `address`, `data`); the display-side read path is unchanged.

## Interface
Parameters:
- NUM_SPRITES, default 2: number of sprite RAMs driven. Legal range is 1..64.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- select  in  6  sprite number, sampled together with start.
- pix_valid  in  1  pixel stream valid.
- pix_data  in  2  pixel value.
- pix_ready  out  1  loader can accept a pixel this cycle.
- ram_wen  out  NUM_SPRITES  one-hot write enable; bit n drives sprite RAM n.
- ram_address  out  8  {x, y}: x in [7:4], y in [3:0].
- ram_data  out  2  pixel written.
- busy  out  1  high in LOAD.
- done  out  1  one-cycle pulse when the sprite load completes.
- err  out  1  one-cycle pulse when start has an illegal select.
- checksum  out  10  pixel sum of the last completed load (see Configuration).

## Operation
- States: IDLE, LOAD.
- IDLE, start=1, select < NUM_SPRITES:
  - Latch select into sel_q.
  - Clear the 8-bit pixel counter cnt = {x, y} and the running sum.
  - Go to LOAD.
- IDLE, start=1, select >= NUM_SPRITES:
  - err=1 for the next cycle.
  - Stay in IDLE; no write is issued.
- IDLE: pix_ready=0, and pixels presented are not consumed.
- LOAD: pix_ready=1 every cycle; there is no backpressure from the RAM.
- A pixel is accepted when pix_valid & pix_ready. Then:
  - ram_address <= cnt and ram_data <= pix_data.
  - ram_wen <= (1 << sel_q).
  - cnt <= cnt + 1.
- Write order: y is the fast index, x the slow one. Address 0x00, 0x01 … 0x0F, 0x10 … 0xFF.
- If no pixel is accepted in a cycle, ram_wen is 0 in the next cycle. ram_address and ram_data hold their last values.
- Accepting the 256th pixel (cnt = 0xFF):
  - The counter wraps to 0x00.
  - The state returns to IDLE.
  - done=1 in the same cycle the last write is presented (ram_wen active at address 0xFF).
- start during LOAD is ignored. It does not retarget the load, restart it, or set err.
- Reset mid-load:
  - State goes to IDLE and all outputs return to reset values.
  - The partially written sprite keeps the pixels already written; there is no rollback.
- Sprite RAMs with index >= NUM_SPRITES do not exist; their writes cannot occur.

## Timing
- Reset values: pix_ready=0, busy=0, done=0, err=0, ram_wen=0, ram_address=0x00, ram_data=0, checksum=0.
- Latency:
  - start to first possible acceptance: 1 cycle (pix_ready high the cycle after start).
  - Acceptance to RAM write: 1 cycle (registered outputs).
- Throughput: 1 pixel/cycle, so a full sprite loads in 256 cycles minimum.
- err and done are single-cycle pulses; they never overlap.
- busy = (state == LOAD) and equals pix_ready.
- A new start is accepted in the cycle after the done pulse (IDLE).

## Configuration
- SPRITE_LOADER_CHECKSUM_EN defined:
  - A 10-bit running sum of accepted pix_data is kept during LOAD.
  - checksum is updated with the final sum in the same cycle done pulses, and holds until the next done or reset.
  - The maximum sum is 256*3 = 768, so 10 bits never overflow.
- SPRITE_LOADER_CHECKSUM_EN undefined:
  - The sum logic is removed.
  - checksum is tied to 0.

## Test plan
- Reset, then start with select=0, then 256 pixels (pix_data = index mod 4) with pix_valid held high -> 256 writes with ram_wen=2'b01 at addresses 0x00..0xFF in order; ram_data matches; done pulses with the 0xFF write; with CHECKSUM_EN, checksum=384.
- start select=1, pixels all 3, pix_valid toggling every other cycle -> ram_wen=2'b10 only; 256 writes over about 512 cycles; no write in idle gaps; checksum=768.
- start select=5 (NUM_SPRITES=2) -> err pulses for 1 cycle; pix_ready stays 0; no ram_wen.
- During LOAD after 10 pixels, assert start with select=0 -> ignored; the load continues at address 0x0A; err stays 0.
- Assert reset after 100 pixels -> next cycle all outputs at reset values, state IDLE; a new start with select=0 writes from address 0x00.
- Two back-to-back loads (sprite 0, then sprite 1) with start in the cycle after done -> second load accepted; the counter restarts at 0x00.
